// File: rtl/lsq_pkg.sv
// Shared types and encodings for the load/store queue.
package lsq_pkg;

  localparam int unsigned ROB_IDX  = 4;
  localparam int unsigned INST_OPT = 4;

  // A source tag of zero means the operand value is already present.
  localparam logic [ROB_IDX-1:0] ZERO_ROB_IDX = '0;

  localparam logic [3:0] LEN_BYTE = 4'd0;
  localparam logic [3:0] LEN_HALF = 4'd1;
  localparam logic [3:0] LEN_WORD = 4'd3;

  typedef enum logic [INST_OPT-1:0] {
    OptNop = 4'd0,
    OptLb  = 4'd1,
    OptLh  = 4'd2,
    OptLw  = 4'd3,
    OptLbu = 4'd4,
    OptLhu = 4'd5,
    OptSb  = 4'd6,
    OptSh  = 4'd7,
    OptSw  = 4'd8
  } inst_opt_e;

  typedef enum logic [1:0] {
    StIdle,
    StLoading,
    StStoring
  } lsq_state_e;

  typedef struct packed {
    logic                busy;
    logic [INST_OPT-1:0] opt;
    logic [ROB_IDX-1:0]  src1;
    logic [ROB_IDX-1:0]  src2;
    logic [ROB_IDX-1:0]  dest;
    logic [31:0]         val1;
    logic [31:0]         val2;
    logic [31:0]         imm;
  } lsq_entry_t;

  function automatic logic is_load(input logic [INST_OPT-1:0] opt);
    case (opt)
      OptLb, OptLh, OptLw, OptLbu, OptLhu: is_load = 1'b1;
      default:                             is_load = 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input logic [INST_OPT-1:0] opt);
    case (opt)
      OptSb, OptSh, OptSw: is_store = 1'b1;
      default:             is_store = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] mem_len(input logic [INST_OPT-1:0] opt);
    case (opt)
      OptLb, OptLbu, OptSb: mem_len = LEN_BYTE;
      OptLh, OptLhu, OptSh: mem_len = LEN_HALF;
      default:              mem_len = LEN_WORD;
    endcase
  endfunction

  function automatic logic ld_sext(input logic [INST_OPT-1:0] opt);
    ld_sext = (opt == OptLb) || (opt == OptLh);
  endfunction

endpackage

// File: rtl/cdb_snoop.sv
// Matches one operand tag against all CDB ports; lowest-numbered matching port wins.
module cdb_snoop
  import lsq_pkg::*;
#(
  parameter int unsigned NCDB = 2
) (
  input  logic [ROB_IDX-1:0]      src,
  input  logic [31:0]             val,
  input  logic [NCDB-1:0]         cdb_valid,
  input  logic [NCDB*ROB_IDX-1:0] cdb_src,
  input  logic [NCDB*32-1:0]      cdb_val,
  output logic [ROB_IDX-1:0]      new_src,
  output logic [31:0]             new_val
);

  // Scan from the highest port down so the lowest matching port is applied last.
  always_comb begin
    new_src = src;
    new_val = val;
    for (int i = NCDB - 1; i >= 0; i--) begin
      if (src != ZERO_ROB_IDX && cdb_valid[i] && cdb_src[i*ROB_IDX +: ROB_IDX] == src) begin
        new_src = ZERO_ROB_IDX;
        new_val = cdb_val[i*32 +: 32];
      end
    end
  end

endmodule

// File: rtl/lsq.sv
// Load/store queue: in-order circular buffer with CDB snooping and a
// single-outstanding memory transaction dispatched from the head.
module lsq
  import lsq_pkg::*;
#(
  parameter int unsigned QBIT        = 4,
  parameter int unsigned NCDB        = 2,
  parameter int unsigned FULL_MARGIN = 3,
  parameter logic [1:0]  IO_HI       = 2'b11
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      flush,
  input  logic                      stall,
  output logic                      full,
  output logic                      empty,
  input  logic                      id_valid,
  input  logic [INST_OPT-1:0]       id_opt,
  input  logic [ROB_IDX-1:0]        id_src1,
  input  logic [ROB_IDX-1:0]        id_src2,
  input  logic [ROB_IDX-1:0]        id_rob,
  input  logic [31:0]               id_val1,
  input  logic [31:0]               id_val2,
  input  logic [31:0]               id_imm,
  input  logic [NCDB-1:0]           cdb_valid,
  input  logic [NCDB*ROB_IDX-1:0]   cdb_src,
  input  logic [NCDB*32-1:0]        cdb_val,
  output logic                      mc_ld_ena,
  output logic [31:0]               mc_ld_addr,
  output logic [3:0]                mc_ld_len,
  output logic                      mc_ld_sext,
  output logic [ROB_IDX-1:0]        mc_ld_src,
  input  logic                      mc_ld_done,
  output logic                      mc_st_ena,
  output logic [31:0]               mc_st_addr,
  output logic [3:0]                mc_st_len,
  output logic [31:0]               mc_st_data,
  input  logic                      mc_st_done,
  output logic                      rob_req_valid,
  output logic [ROB_IDX-1:0]        rob_req_idx,
  input  logic [ROB_IDX-1:0]        rob_head,
  input  logic                      rob_commit_rdy
);

  localparam int unsigned   DEPTH     = 1 << QBIT;
  localparam logic [QBIT:0] DEPTH_CNT = (QBIT + 1)'(DEPTH);
  localparam logic [QBIT:0] FULL_AT   = (QBIT + 1)'(DEPTH - FULL_MARGIN);

  lsq_entry_t      mem_q [DEPTH];
  lsq_entry_t      mem_d [DEPTH];
  logic [QBIT-1:0] head_q, head_d, tail_q, tail_d;
  logic [QBIT:0]   count_q, count_d;
  lsq_state_e      state_q, state_d;

  logic               ld_ena_q, ld_ena_d, ld_sext_q, ld_sext_d;
  logic [31:0]        ld_addr_q, ld_addr_d;
  logic [3:0]         ld_len_q, ld_len_d;
  logic [ROB_IDX-1:0] ld_src_q, ld_src_d;
  logic               st_ena_q, st_ena_d;
  logic [31:0]        st_addr_q, st_addr_d, st_data_q, st_data_d;
  logic [3:0]         st_len_q, st_len_d;

  assign full  = count_q >= FULL_AT;
  assign empty = count_q == '0;

  // Issue-path operand capture so a same-cycle broadcast is not missed.
  logic [ROB_IDX-1:0] id_src1_s, id_src2_s;
  logic [31:0]        id_val1_s, id_val2_s;

  cdb_snoop #(.NCDB(NCDB)) u_snoop_id1 (
    .src(id_src1), .val(id_val1), .cdb_valid(cdb_valid), .cdb_src(cdb_src),
    .cdb_val(cdb_val), .new_src(id_src1_s), .new_val(id_val1_s)
  );
  cdb_snoop #(.NCDB(NCDB)) u_snoop_id2 (
    .src(id_src2), .val(id_val2), .cdb_valid(cdb_valid), .cdb_src(cdb_src),
    .cdb_val(cdb_val), .new_src(id_src2_s), .new_val(id_val2_s)
  );

  logic [ROB_IDX-1:0] ent_src1 [DEPTH];
  logic [ROB_IDX-1:0] ent_src2 [DEPTH];
  logic [31:0]        ent_val1 [DEPTH];
  logic [31:0]        ent_val2 [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    cdb_snoop #(.NCDB(NCDB)) u_snoop_s1 (
      .src(mem_q[g].src1), .val(mem_q[g].val1), .cdb_valid(cdb_valid), .cdb_src(cdb_src),
      .cdb_val(cdb_val), .new_src(ent_src1[g]), .new_val(ent_val1[g])
    );
    cdb_snoop #(.NCDB(NCDB)) u_snoop_s2 (
      .src(mem_q[g].src2), .val(mem_q[g].val2), .cdb_valid(cdb_valid), .cdb_src(cdb_src),
      .cdb_val(cdb_val), .new_src(ent_src2[g]), .new_val(ent_val2[g])
    );
  end

  // Head decode and dispatch conditions.
  lsq_entry_t  head_ent;
  logic [31:0] head_addr;
  logic        head_io, commit_ok, can_issue, ld_go, st_go, push, pop;

  assign head_ent  = mem_q[head_q];
  assign head_addr = head_ent.val1 + head_ent.imm;
  assign head_io   = head_addr[17:16] == IO_HI;
  assign commit_ok = rob_commit_rdy && (rob_head == head_ent.dest);
  assign can_issue = (state_q == StIdle) && !empty && !flush;
  assign ld_go     = can_issue && is_load(head_ent.opt) && head_ent.src1 == ZERO_ROB_IDX &&
                     (!head_io || commit_ok);
  assign rob_req_valid = can_issue && is_store(head_ent.opt) &&
                         head_ent.src1 == ZERO_ROB_IDX && head_ent.src2 == ZERO_ROB_IDX;
  assign rob_req_idx   = head_ent.dest;
  assign st_go     = rob_req_valid && commit_ok;
  assign pop       = ld_go || st_go;
  assign push      = id_valid && !stall && !flush && count_q != DEPTH_CNT;

  // Queue next state: snoop busy entries, then pop, push, and flush overrides all.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (mem_q[i].busy) begin
        mem_d[i].src1 = ent_src1[i];
        mem_d[i].val1 = ent_val1[i];
        mem_d[i].src2 = ent_src2[i];
        mem_d[i].val2 = ent_val2[i];
      end
    end
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop) begin
      mem_d[head_q].busy = 1'b0;
      head_d = head_q + 1'b1;
    end
    if (push) begin
      mem_d[tail_q] = '{busy: 1'b1, opt: id_opt, src1: id_src1_s, src2: id_src2_s,
                        dest: id_rob, val1: id_val1_s, val2: id_val2_s, imm: id_imm};
      tail_d = tail_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_d[i] = '0;
      end
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Memory-channel FSM; a committed store survives flush, a load does not.
  always_comb begin
    state_d   = state_q;
    ld_ena_d  = ld_ena_q;
    ld_addr_d = ld_addr_q;
    ld_len_d  = ld_len_q;
    ld_sext_d = ld_sext_q;
    ld_src_d  = ld_src_q;
    st_ena_d  = st_ena_q;
    st_addr_d = st_addr_q;
    st_len_d  = st_len_q;
    st_data_d = st_data_q;
    unique case (state_q)
      StIdle: begin
        if (ld_go) begin
          state_d   = StLoading;
          ld_ena_d  = 1'b1;
          ld_addr_d = head_addr;
          ld_len_d  = mem_len(head_ent.opt);
          ld_sext_d = ld_sext(head_ent.opt);
          ld_src_d  = head_ent.dest;
        end else if (st_go) begin
          state_d   = StStoring;
          st_ena_d  = 1'b1;
          st_addr_d = head_addr;
          st_len_d  = mem_len(head_ent.opt);
          st_data_d = head_ent.val2;
        end
      end
      StLoading: begin
        if (flush || mc_ld_done) begin
          state_d  = StIdle;
          ld_ena_d = 1'b0;
        end
      end
      StStoring: begin
        if (mc_st_done) begin
          state_d  = StIdle;
          st_ena_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers: reset dominates, rdy low freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      state_q   <= StIdle;
      ld_ena_q  <= 1'b0;
      ld_addr_q <= '0;
      ld_len_q  <= '0;
      ld_sext_q <= 1'b0;
      ld_src_q  <= '0;
      st_ena_q  <= 1'b0;
      st_addr_q <= '0;
      st_len_q  <= '0;
      st_data_q <= '0;
    end else if (rdy) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      state_q   <= state_d;
      ld_ena_q  <= ld_ena_d;
      ld_addr_q <= ld_addr_d;
      ld_len_q  <= ld_len_d;
      ld_sext_q <= ld_sext_d;
      ld_src_q  <= ld_src_d;
      st_ena_q  <= st_ena_d;
      st_addr_q <= st_addr_d;
      st_len_q  <= st_len_d;
      st_data_q <= st_data_d;
    end
  end

  assign mc_ld_ena  = ld_ena_q;
  assign mc_ld_addr = ld_addr_q;
  assign mc_ld_len  = ld_len_q;
  assign mc_ld_sext = ld_sext_q;
  assign mc_ld_src  = ld_src_q;
  assign mc_st_ena  = st_ena_q;
  assign mc_st_addr = st_addr_q;
  assign mc_st_len  = st_len_q;
  assign mc_st_data = st_data_q;

endmodule

// File: tb/tb_lsq.sv
// Directed bench for the load/store queue.
module tb_lsq;
  import lsq_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst, rdy, flush, stall;
  logic                    full, empty;
  logic                    id_valid;
  logic [INST_OPT-1:0]     id_opt;
  logic [ROB_IDX-1:0]      id_src1, id_src2, id_rob;
  logic [31:0]             id_val1, id_val2, id_imm;
  logic [1:0]              cdb_valid;
  logic [2*ROB_IDX-1:0]    cdb_src;
  logic [63:0]             cdb_val;
  logic                    mc_ld_ena, mc_ld_sext, mc_ld_done;
  logic [31:0]             mc_ld_addr;
  logic [3:0]              mc_ld_len;
  logic [ROB_IDX-1:0]      mc_ld_src;
  logic                    mc_st_ena, mc_st_done;
  logic [31:0]             mc_st_addr, mc_st_data;
  logic [3:0]              mc_st_len;
  logic                    rob_req_valid, rob_commit_rdy;
  logic [ROB_IDX-1:0]      rob_req_idx, rob_head;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lsq dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .stall(stall),
    .full(full), .empty(empty),
    .id_valid(id_valid), .id_opt(id_opt), .id_src1(id_src1), .id_src2(id_src2),
    .id_rob(id_rob), .id_val1(id_val1), .id_val2(id_val2), .id_imm(id_imm),
    .cdb_valid(cdb_valid), .cdb_src(cdb_src), .cdb_val(cdb_val),
    .mc_ld_ena(mc_ld_ena), .mc_ld_addr(mc_ld_addr), .mc_ld_len(mc_ld_len),
    .mc_ld_sext(mc_ld_sext), .mc_ld_src(mc_ld_src), .mc_ld_done(mc_ld_done),
    .mc_st_ena(mc_st_ena), .mc_st_addr(mc_st_addr), .mc_st_len(mc_st_len),
    .mc_st_data(mc_st_data), .mc_st_done(mc_st_done),
    .rob_req_valid(rob_req_valid), .rob_req_idx(rob_req_idx),
    .rob_head(rob_head), .rob_commit_rdy(rob_commit_rdy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic drive_push(input logic [3:0] opt, input logic [3:0] s1, input logic [31:0] v1,
                            input logic [3:0] s2, input logic [31:0] v2,
                            input logic [31:0] imm, input logic [3:0] dest);
    id_valid = 1'b1;
    id_opt   = opt;
    id_src1  = s1;
    id_val1  = v1;
    id_src2  = s2;
    id_val2  = v2;
    id_imm   = imm;
    id_rob   = dest;
  endtask

  task automatic cdb_off();
    cdb_valid = '0;
    cdb_src   = '0;
    cdb_val   = '0;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; stall = 1'b0;
    id_valid = 1'b0; id_opt = '0; id_src1 = '0; id_src2 = '0; id_rob = '0;
    id_val1 = '0; id_val2 = '0; id_imm = '0;
    cdb_off();
    mc_ld_done = 1'b0; mc_st_done = 1'b0; rob_head = '0; rob_commit_rdy = 1'b0;
    step(); step();
    rst = 1'b0;
    #1;
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_ld_ena", mc_ld_ena, 0);
    check("rst_st_ena", mc_st_ena, 0);
    check("rst_rob_req", rob_req_valid, 0);
    check("rst_ld_addr", mc_ld_addr, 0);

    // Simple ready load
    drive_push(OptLw, 4'd0, 32'h100, 4'd0, 32'h0, 32'h4, 4'd3);
    step();
    id_valid = 1'b0;
    check("lw_queued", empty, 0);
    step();
    check("lw_ena", mc_ld_ena, 1);
    check("lw_addr", mc_ld_addr, 32'h104);
    check("lw_len", mc_ld_len, 3);
    check("lw_sext", mc_ld_sext, 0);
    check("lw_src", mc_ld_src, 3);
    check("lw_popped", empty, 1);
    mc_ld_done = 1'b1;
    step();
    mc_ld_done = 1'b0;
    check("lw_done_ena", mc_ld_ena, 0);

    // Store waiting on src2, woken by CDB port 1
    drive_push(OptSw, 4'd0, 32'h200, 4'd5, 32'h0, 32'h8, 4'd6);
    step();
    id_valid = 1'b0;
    #1;
    check("sw_not_ready", rob_req_valid, 0);
    cdb_valid = 2'b10; cdb_src = {4'd5, 4'd0}; cdb_val = {32'hAB, 32'h0};
    step();
    cdb_off();
    #1;
    check("sw_req_valid", rob_req_valid, 1);
    check("sw_req_idx", rob_req_idx, 6);
    rob_head = 4'd6; rob_commit_rdy = 1'b1;
    step();
    rob_commit_rdy = 1'b0;
    check("sw_ena", mc_st_ena, 1);
    check("sw_data", mc_st_data, 32'hAB);
    check("sw_addr", mc_st_addr, 32'h208);
    check("sw_len", mc_st_len, 3);
    mc_st_done = 1'b1;
    step();
    mc_st_done = 1'b0;
    check("sw_done_ena", mc_st_ena, 0);

    // I/O-region load waits for commit
    drive_push(OptLb, 4'd0, 32'h30000, 4'd0, 32'h0, 32'h0, 4'd7);
    rob_head = 4'd6; rob_commit_rdy = 1'b1;
    step();
    id_valid = 1'b0;
    step();
    check("io_held", mc_ld_ena, 0);
    rob_head = 4'd7;
    step();
    rob_commit_rdy = 1'b0;
    check("io_ena", mc_ld_ena, 1);
    check("io_addr", mc_ld_addr, 32'h30000);
    check("io_sext", mc_ld_sext, 1);
    check("io_len", mc_ld_len, 0);
    mc_ld_done = 1'b1;
    step();
    mc_ld_done = 1'b0;

    // Same-cycle push with both CDB ports matching: port 0 wins
    drive_push(OptLw, 4'd9, 32'h0, 4'd0, 32'h0, 32'h10, 4'd2);
    cdb_valid = 2'b11; cdb_src = {4'd9, 4'd9}; cdb_val = {32'h22, 32'h11};
    step();
    id_valid = 1'b0;
    cdb_off();
    step();
    check("push_snoop_addr", mc_ld_addr, 32'h21);
    check("push_snoop_ena", mc_ld_ena, 1);
    mc_ld_done = 1'b1;
    step();
    mc_ld_done = 1'b0;

    // In-queue capture with both ports matching: port 0 wins
    drive_push(OptLhu, 4'd4, 32'h0, 4'd0, 32'h0, 32'h8, 4'd1);
    step();
    id_valid = 1'b0;
    cdb_valid = 2'b11; cdb_src = {4'd4, 4'd4}; cdb_val = {32'h80, 32'h40};
    step();
    cdb_off();
    step();
    check("q_snoop_addr", mc_ld_addr, 32'h48);
    check("q_snoop_len", mc_ld_len, 1);
    check("q_snoop_sext", mc_ld_sext, 0);
    mc_ld_done = 1'b1;
    step();
    mc_ld_done = 1'b0;

    // Fill with blocked loads, overfill, then drain in order across the wrap
    for (int i = 0; i < 16; i++) begin
      drive_push(OptLw, 4'd15, 32'h0, 4'd0, 32'h0, 32'(i * 4), 4'd1);
      step();
      if (i == 11) check("fill12_not_full", full, 0);
      if (i == 12) check("fill13_full", full, 1);
    end
    for (int i = 0; i < 16; i++) begin
      drive_push(OptLw, 4'd15, 32'h0, 4'd0, 32'h0, 32'hF00, 4'd1);
      step();
    end
    id_valid = 1'b0;
    check("over_full", full, 1);
    check("over_not_empty", empty, 0);
    cdb_valid = 2'b01; cdb_src = {4'd0, 4'd15}; cdb_val = {32'h0, 32'h1000};
    step();
    cdb_off();
    for (int i = 0; i < 16; i++) begin
      step();
      check("drain_ena", mc_ld_ena, 1);
      check("drain_addr", mc_ld_addr, 32'h1000 + 32'(i * 4));
      mc_ld_done = 1'b1;
      step();
      mc_ld_done = 1'b0;
    end
    check("drain_empty", empty, 1);

    // Flush while storing: store completes, queue cleared, flushed push discarded
    drive_push(OptSh, 4'd0, 32'h300, 4'd0, 32'h55, 32'h0, 4'd8);
    step();
    drive_push(OptLw, 4'd15, 32'h0, 4'd0, 32'h0, 32'h0, 4'd10);
    rob_head = 4'd8; rob_commit_rdy = 1'b1;
    step();
    rob_commit_rdy = 1'b0;
    check("fst_ena", mc_st_ena, 1);
    check("fst_data", mc_st_data, 32'h55);
    check("fst_len", mc_st_len, 1);
    check("fst_not_empty", empty, 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    id_valid = 1'b0;
    check("fst_empty", empty, 1);
    check("fst_held1", mc_st_ena, 1);
    step();
    check("fst_held2", mc_st_ena, 1);
    mc_st_done = 1'b1;
    step();
    mc_st_done = 1'b0;
    check("fst_done", mc_st_ena, 0);
    check("fst_still_empty", empty, 1);

    // Flush while loading aborts the load
    drive_push(OptLw, 4'd0, 32'h500, 4'd0, 32'h0, 32'h0, 4'd9);
    step();
    id_valid = 1'b0;
    step();
    check("fld_ena", mc_ld_ena, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("fld_abort", mc_ld_ena, 0);
    check("fld_empty", empty, 1);

    // rdy low freezes dispatch and ignores done
    drive_push(OptLw, 4'd0, 32'h600, 4'd0, 32'h0, 32'h0, 4'd11);
    step();
    id_valid = 1'b0;
    rdy = 1'b0;
    step(); step();
    check("frz_no_ld", mc_ld_ena, 0);
    check("frz_not_empty", empty, 0);
    rdy = 1'b1;
    step();
    check("frz_ld", mc_ld_ena, 1);
    check("frz_addr", mc_ld_addr, 32'h600);
    rdy = 1'b0;
    mc_ld_done = 1'b1;
    step();
    check("frz_done_ign", mc_ld_ena, 1);
    rdy = 1'b1;
    step();
    mc_ld_done = 1'b0;
    check("frz_done", mc_ld_ena, 0);

    // Reset mid-load abandons the transaction and empties the queue
    drive_push(OptLw, 4'd0, 32'h700, 4'd0, 32'h0, 32'h0, 4'd12);
    step();
    drive_push(OptLw, 4'd15, 32'h0, 4'd0, 32'h0, 32'h0, 4'd13);
    step();
    id_valid = 1'b0;
    check("rl_ena", mc_ld_ena, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rl_abort", mc_ld_ena, 0);
    check("rl_empty", empty, 1);
    check("rl_addr", mc_ld_addr, 0);
    check("rl_src", mc_ld_src, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsq.md
LSQ -- requirements
Module: lsq

Interface
REQ-001 Parameter QBIT, default 4, log2 of queue depth; DEPTH = 2^QBIT.
REQ-002 Parameter NCDB, default 2, number of CDB broadcast ports.
REQ-003 Parameter FULL_MARGIN, default 3, free-slot reserve below which full asserts.
REQ-004 Parameter IO_HI, default 2'b11, value of addr[17:16] that marks the I/O region.
REQ-005 clk  in  1  clock; reset rst, synchronous, active-high; clock clk.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 rdy  in  1  global enable; low freezes all state.
REQ-008 flush  in  1  misprediction rollback; stall  in  1  issue stall.
REQ-009 full  out  1, empty  out  1  occupancy flags to the issue unit.
REQ-010 id_valid in 1, id_opt in INST_OPT width, id_src1/id_src2/id_rob in ROB_IDX width, id_val1/id_val2/id_imm in 32  issue packet; src==0 means the value is ready.
REQ-011 cdb_valid in NCDB, cdb_src in NCDB*ROB_IDX width, cdb_val in NCDB*32  packed CDB broadcast ports.
REQ-012 mc_ld_ena out 1, mc_ld_addr out 32, mc_ld_len out 4, mc_ld_sext out 1, mc_ld_src out ROB_IDX width, mc_ld_done in 1  load channel.
REQ-013 mc_st_ena out 1, mc_st_addr out 32, mc_st_len out 4, mc_st_data out 32, mc_st_done in 1  store channel.
REQ-014 rob_req_valid out 1, rob_req_idx out ROB_IDX width  head-ready request; rob_head in ROB_IDX width, rob_commit_rdy in 1  commit grant.

Function
REQ-015 The queue SHALL be a circular buffer with head, tail and an exact count register of QBIT+1 bits; no lagged size.
REQ-016 full SHALL be combinational: count >= DEPTH-FULL_MARGIN; empty SHALL be count==0.
REQ-017 A push SHALL occur when id_valid && !stall && !flush && rdy; tail SHALL advance modulo DEPTH.
REQ-018 A push with count==DEPTH SHALL be dropped with state unchanged.
REQ-019 At push, a src matching a valid CDB port SHALL be stored as 0 with that port's value; the lowest-numbered matching port wins.
REQ-020 Every cycle, each busy entry SHALL capture every matching valid CDB port for src1 and src2, again with the lowest port winning.
REQ-021 Simultaneous push and pop SHALL leave count unchanged.
REQ-022 The FSM SHALL have states IDLE, LOADING and STORING, and dispatch SHALL be from the head only, in IDLE, with a non-empty queue.
REQ-023 Head load: ready when src1==0; the effective address is val1+imm mod 2^32.
REQ-024 If the effective address has addr[17:16]==IO_HI, the load SHALL additionally wait for rob_commit_rdy && rob_head==dest.
REQ-025 Load dispatch SHALL, on the next edge, set mc_ld_ena, addr, src, len (LB/LBU=0, LH/LHU=1, LW=3) and sext (LB/LH=1), pop the head and enter LOADING.
REQ-026 Head store: ready when src1==0 && src2==0; rob_req_valid SHALL assert combinationally while ready and IDLE with !flush, and rob_req_idx SHALL equal dest.
REQ-027 A store SHALL dispatch on rob_commit_rdy && rob_head==dest: set mc_st_ena, addr, data, len (SB=0, SH=1, SW=3), pop the head and enter STORING.
REQ-028 LOADING+mc_ld_done or STORING+mc_st_done SHALL, on the next edge, clear the enable and return to IDLE; the earliest next dispatch is the following cycle.
REQ-029 flush SHALL clear all entries and zero head, tail and count in one cycle.
REQ-030 On flush, LOADING SHALL abort to IDLE with mc_ld_ena=0.
REQ-031 On flush, STORING SHALL be held until mc_st_done, because the store is committed.
REQ-032 A push in the same cycle as flush SHALL be discarded.
REQ-033 rdy low SHALL freeze all registers; done inputs SHALL be ignored while frozen.

Reset
REQ-034 rst SHALL have priority over flush and rdy.
REQ-035 On rst: FSM=IDLE; head/tail/count=0; all busy=0; mc_ld_ena=mc_st_ena=0; addr/data/len/src outputs=0.
REQ-036 rst mid-LOADING or mid-STORING SHALL abandon the transaction.

Structure
REQ-037 ROB_IDX width, INST_OPT codes, ZERO_ROB_IDX and load/store length encodings SHALL live in the shared utils package.
REQ-038 The CDB match-and-select logic SHALL be one sub-module, cdb_snoop, instantiated for the issue path and per entry operand.

Verification
REQ-039 Push LW src1=0, val1=0x100, imm=4 -> next cycle mc_ld_ena=1, addr=0x104, len=3; mc_ld_done -> IDLE on the next edge.
REQ-040 Push SW src2=5; cdb port1 src=5, val=0xAB -> rob_req_valid=1; rob_head match + commit -> mc_st_data=0xAB.
REQ-041 Push LB with addr 0x30000 -> no dispatch until rob_head==dest && rob_commit_rdy; then sext=1, len=0.
REQ-042 Fill to DEPTH-3 -> full=1; push 16 more with DEPTH=16 -> count saturates at 16 and tail wraps correctly.
REQ-043 flush during STORING -> queue empty, mc_st_ena held until mc_st_done; flush during LOADING -> mc_ld_ena=0 on the next edge.
REQ-044 Same-cycle push and CDB match on both ports for one src -> the port0 value is captured.
